// File: rtl/ifu_pkg.sv
// Shared fetch-unit constants: address/instruction widths, reset PC, NOP word, FSM encoding.
package ifu_pkg;

    localparam int          IFU_XLEN     = 64;
    localparam int          IFU_ILEN     = 32;
    localparam logic [63:0] IFU_RESET_PC = 64'h0000_0000_8000_0000;
    localparam logic [31:0] IFU_NOP      = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_VALID = 2'd3
    } ifu_state_t;

endpackage

// File: rtl/ifu.sv
// Instruction fetch unit: owns the PC, one outstanding imem fetch, one registered instruction to decode.
// Latency: request 1 cycle after reset release; instruction valid 2 cycles after request with zero-wait memory.
// Backpressure: instruction held in VALID until instr_ready; request held in REQ until imem_req_ready.
module ifu
    import ifu_pkg::*;
#(
    parameter int              XLEN     = IFU_XLEN,
    parameter int              ILEN     = IFU_ILEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(IFU_RESET_PC)
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    input  logic            imem_rsp_err,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [ILEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_o,
    output logic            fault_o,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);

    ifu_state_t      state_q, state_d;
    logic [XLEN-1:0] pc_q;
    logic            drop_q;
    logic [ILEN-1:0] instr_q;
    logic [XLEN-1:0] pc_out_q;
    logic            fault_q;
    logic            redir;
    logic            rsp_take;
    logic            redirect_lsb_unused;

    assign redirect_lsb_unused = ^redirect_pc[1:0];

    assign redir    = redirect_valid && (state_q != ST_IDLE);
    assign rsp_take = (state_q == ST_WAIT) && imem_rsp_valid && !drop_q && !redirect_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = ST_REQ;
            ST_REQ:   if (imem_req_ready) state_d = ST_WAIT;
            // A redirect alongside the response throws the word away and refetches.
            ST_WAIT:  if (imem_rsp_valid) state_d = rsp_take ? ST_VALID : ST_REQ;
            ST_VALID: if (instr_ready || redirect_valid) state_d = ST_REQ;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        imem_req_valid = (state_q == ST_REQ);
        instr_valid    = (state_q == ST_VALID);
    end

    assign imem_addr = pc_q;
    assign instr_o   = instr_q;
    assign pc_o      = pc_out_q;
    assign fault_o   = fault_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            drop_q   <= 1'b0;
            instr_q  <= '0;
            pc_out_q <= '0;
            fault_q  <= 1'b0;
        end else begin
            if (redir) begin
                pc_q <= {redirect_pc[XLEN-1:2], 2'b00};
            end else if (state_q == ST_VALID && instr_ready) begin
                pc_q <= pc_q + XLEN'(4);
            end

            // drop marks an in-flight response fetched from a now-stale PC.
            if (state_q == ST_REQ && redir && imem_req_ready) begin
                drop_q <= 1'b1;
            end else if (state_q == ST_WAIT) begin
                if (imem_rsp_valid) begin
                    drop_q <= 1'b0;
                end else if (redir) begin
                    drop_q <= 1'b1;
                end
            end

            if (rsp_take) begin
                instr_q  <= imem_rsp_err ? ILEN'(IFU_NOP) : imem_rsp_data;
                pc_out_q <= pc_q;
                fault_q  <= imem_rsp_err;
            end
        end
    end

endmodule

// File: tb/tb_ifu.sv
// Directed bench for ifu: cycle-scripted memory/decoder stimulus with hand-computed expectations.
module tb_ifu;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_o;
    logic [63:0] pc_o;
    logic        fault_o;
    logic        redirect_valid;
    logic [63:0] redirect_pc;

    int total = 0;
    int bad   = 0;

    ifu dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_o        (instr_o),
        .pc_o           (pc_o),
        .fault_o        (fault_o),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        imem_rsp_err   = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 64'h0;

        step();
        step();
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_addr", imem_addr, 64'h8000_0000);
        chk("rst_instr_valid", instr_valid, 0);
        chk("rst_instr", instr_o, 0);
        chk("rst_pc", pc_o, 0);
        chk("rst_fault", fault_o, 0);

        // cycle 0: IDLE
        rst = 1'b0;
        chk("idle_req_valid", imem_req_valid, 0);
        step(); // cycle 1: REQ
        chk("c1_req_valid", imem_req_valid, 1);
        chk("c1_addr", imem_addr, 64'h8000_0000);
        step(); // cycle 2: WAIT
        chk("c2_req_valid", imem_req_valid, 0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0010_0093;
        step(); // cycle 3: VALID
        imem_rsp_valid = 1'b0;
        chk("c3_instr_valid", instr_valid, 1);
        chk("c3_instr", instr_o, 32'h0010_0093);
        chk("c3_pc", pc_o, 64'h8000_0000);
        chk("c3_fault", fault_o, 0);

        // decoder stall
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_valid", instr_valid, 1);
            chk("stall_instr", instr_o, 32'h0010_0093);
            chk("stall_pc", pc_o, 64'h8000_0000);
            chk("stall_req", imem_req_valid, 0);
        end
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        chk("next_req_valid", imem_req_valid, 1);
        chk("next_addr", imem_addr, 64'h8000_0004);
        chk("next_instr_valid", instr_valid, 0);

        // redirect in WAIT, stale response 3 cycles later
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0103;
        step();
        redirect_valid = 1'b0;
        chk("rw_req_valid", imem_req_valid, 0);
        step();
        chk("rw_wait_ivalid", instr_valid, 0);
        step();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hdead_beef;
        step();
        imem_rsp_valid = 1'b0;
        chk("rw_instr_valid", instr_valid, 0);
        chk("rw_req_valid2", imem_req_valid, 1);
        chk("rw_addr", imem_addr, 64'h8000_0100);

        // redirect same cycle as response
        step();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h1111_1111;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0040;
        step();
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        chk("rs_instr_valid", instr_valid, 0);
        chk("rs_req_valid", imem_req_valid, 1);
        chk("rs_addr", imem_addr, 64'h8000_0040);

        // access fault, then a clean fetch
        step();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hffff_ffff;
        imem_rsp_err   = 1'b1;
        step();
        imem_rsp_valid = 1'b0;
        imem_rsp_err   = 1'b0;
        chk("err_valid", instr_valid, 1);
        chk("err_fault", fault_o, 1);
        chk("err_instr", instr_o, 32'h0000_0013);
        chk("err_pc", pc_o, 64'h8000_0040);
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        chk("err_next_addr", imem_addr, 64'h8000_0044);
        step();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0020_0113;
        step();
        imem_rsp_valid = 1'b0;
        chk("ok_fault", fault_o, 0);
        chk("ok_instr", instr_o, 32'h0020_0113);
        chk("ok_pc", pc_o, 64'h8000_0044);

        // redirect while instruction is consumed
        instr_ready    = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0200;
        step();
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        chk("rv_instr_valid", instr_valid, 0);
        chk("rv_addr", imem_addr, 64'h8000_0200);

        // redirect in REQ with request accepted the same cycle
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0300;
        step();
        redirect_valid = 1'b0;
        chk("rq_req_valid", imem_req_valid, 0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h2222_2222;
        step();
        imem_rsp_valid = 1'b0;
        chk("rq_instr_valid", instr_valid, 0);
        chk("rq_addr", imem_addr, 64'h8000_0300);

        // request held while memory not ready
        imem_req_ready = 1'b0;
        step();
        chk("hold_req_valid", imem_req_valid, 1);
        chk("hold_addr", imem_addr, 64'h8000_0300);
        imem_req_ready = 1'b1;
        step(); // WAIT

        // asynchronous reset in WAIT
        rst = 1'b1;
        #1;
        chk("ar_req_valid", imem_req_valid, 0);
        chk("ar_addr", imem_addr, 64'h8000_0000);
        chk("ar_instr_valid", instr_valid, 0);
        chk("ar_instr", instr_o, 0);
        chk("ar_pc", pc_o, 0);
        chk("ar_fault", fault_o, 0);
        step();
        rst = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h3333_3333;
        imem_req_ready = 1'b0;
        step();
        chk("ar_req_again", imem_req_valid, 1);
        chk("ar_addr_again", imem_addr, 64'h8000_0000);
        chk("ar_ignore_rsp", instr_valid, 0);
        step();
        chk("ar_ignore_rsp2", instr_valid, 0);
        chk("ar_ignore_pc", pc_o, 0);
        imem_rsp_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ifu.md
# ifu

Instruction fetch unit: the producer side of the instruction interface that the decoder consumes. It owns the PC, issues one word-fetch at a time to instruction memory over a valid/ready request plus response-valid channel, and presents one registered instruction with its PC to the decoder under a valid/ready handshake. A redirect port from branch/jump control (the `JalCon`/`JalrCon`/`Beq`… resolution) retargets fetch and squashes any stale in-flight response.

## Interface
Parameters:
- `XLEN`, 64, PC/address width
- `ILEN`, 32, instruction width (matches `` `inst_len``)
- `RESET_PC`, 64'h8000_0000, first fetch address

Ports:
- `clk` in 1: sole clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `imem_req_valid` out 1: fetch request valid
- `imem_req_ready` in 1: memory accepts request
- `imem_addr` out XLEN: fetch address, always 4-byte aligned
- `imem_rsp_valid` in 1: response data valid (one per accepted request, ≥1 cycle after acceptance)
- `imem_rsp_data` in ILEN: fetched word
- `imem_rsp_err` in 1: access fault for this response
- `instr_valid` out 1: `instr_o`/`pc_o` valid to decoder
- `instr_ready` in 1: decoder consumes instruction
- `instr_o` out ILEN: instruction to decoder `instr_i`
- `pc_o` out XLEN: PC of `instr_o`
- `fault_o` out 1: `instr_o` came from an errored fetch (instr_o forced to 32'h0000_0013, NOP)
- `redirect_valid` in 1: taken branch/jump
- `redirect_pc` in XLEN: target; bits [1:0] ignored (cleared)

## Operation
- States: IDLE, REQ, WAIT, VALID; plus `drop` flag (squash next response).
- IDLE: entered on reset; unconditionally → REQ next cycle.
- REQ: `imem_req_valid`=1, `imem_addr`=pc_q. On `imem_req_ready` → WAIT.
- WAIT: on `imem_rsp_valid`: if `drop`, discard, clear `drop`, → REQ; else load `instr_o`, `pc_o`=pc_q, `fault_o`=`imem_rsp_err`, → VALID.
- VALID: `instr_valid`=1; outputs held stable until `instr_ready`; on `instr_ready` pc_q←pc_q+4 (mod 2^XLEN, wrap allowed) → REQ.
- Redirect (highest priority, any state except IDLE): pc_q←{redirect_pc[XLEN-1:2],2'b00}; next state REQ, except:
  - REQ with request accepted same cycle → WAIT with `drop`=1.
  - WAIT with no response this cycle → stay WAIT, `drop`=1.
  - WAIT with response this cycle → response discarded, → REQ.
  - VALID with `instr_ready` same cycle: instruction counts consumed; next fetch from redirect target, not pc+4.
- Redirect in IDLE ignored.
- At most one request outstanding; no request issued while WAIT or VALID.
- `imem_addr` may change while `imem_req_valid`=1 only on redirect; memory samples at handshake.

## Timing
- Reset values: `imem_req_valid`=0, `imem_addr`=RESET_PC, `instr_valid`=0, `instr_o`=0, `pc_o`=0, `fault_o`=0, pc_q=RESET_PC, `drop`=0, state IDLE.
- First request: cycle 1 after reset deasserts.
- Zero-wait memory (ready=1, rsp one cycle after accept): REQ→WAIT→VALID, instruction valid 2 cycles after request; steady throughput 1 instruction / 3 cycles with `instr_ready`=1.
- All outputs registered; no combinational path from any input to any output.
- Reset mid-operation: immediate return to reset values; a response arriving after reset release while in IDLE/REQ is ignored.

## Structure
- `RESET_PC`, `XLEN`, `inst_len`, NOP constant and state encodings belong in the shared `defines.v`.
- Single module; no sub-module warranted (pc+4 adder and FSM inline).

## Test plan
- Reset release, mem ready=1, 1-cycle rsp returning 0x00100093 → request addr 0x8000_0000 at cycle 1; `instr_valid`=1, `instr_o`=0x00100093, `pc_o`=0x8000_0000 at cycle 3; next request addr 0x8000_0004.
- `instr_ready`=0 for 5 cycles in VALID → `instr_o`/`pc_o` stable, `imem_req_valid`=0 throughout.
- Redirect to 0x8000_0103 in WAIT, rsp 3 cycles later → that rsp discarded, next request addr 0x8000_0100, decoder never sees old word.
- Redirect to 0x8000_0040 same cycle as response in WAIT → response dropped, next request 0x8000_0040.
- `imem_rsp_err`=1 → `fault_o`=1, `instr_o`=0x0000_0013; following fetch `fault_o`=0.
- Assert `rst` while WAIT → all outputs reset values within the same cycle; after release, request re-issued at RESET_PC.
